// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg
// Shared definitions for the SNN step sequencer. It holds the core address map
// region codes, the address bit positions, the sequencer state enum and a
// helper that builds a bus address from a core index and a region.
package snn_ctrl_pkg;

  localparam logic [1:0] REG_SPIKE_IN  = 2'b00;
  localparam logic [1:0] REG_PARAM_IN  = 2'b01;
  localparam logic [1:0] REG_SPIKE_OUT = 2'b10;
  localparam logic [1:0] REG_EN_CALC   = 2'b11;

  localparam int CORE_BIT   = 16;
  localparam int REGION_LSB = 17;

  // The "next core / next step / finish" decision is made in the EMIT
  // handshake cycle itself. That keeps a core at 7 cycles minimum, and it
  // lets done_o rise in the cycle right after the last output transfer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_IN,
    ST_WR_IN,
    ST_WR_CALC,
    ST_WAIT_DONE,
    ST_RD_OUT,
    ST_WAIT_RDATA,
    ST_EMIT
  } seq_state_e;

  // Every address bit outside the core select and the region field stays 0.
  function automatic logic [31:0] make_addr(input logic core, input logic [1:0] region);
    logic [31:0] addr;
    addr = '0;
    addr[CORE_BIT] = core;
    addr[REGION_LSB +: 2] = region;
    return addr;
  endfunction

endpackage

// File: rtl/snn_step_sequencer.sv
// snn_step_sequencer
// Bus master that runs the two-core SNN for num_steps_i timesteps. For each
// timestep it handles core 0 and then core 1. For each core it takes one input
// spike word from the stream and writes it to the core. It then writes the
// calculation enable and waits for that core's done pulse. Finally it reads the
// output spike word back and presents it on the output stream.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   start_i, num_steps_i          start pulse (IDLE only) and timestep count
//   busy_o, done_o, error_o       status: running, completion pulse, sticky timeout
//   step_cnt_o                    completed timesteps
//   spike_in_*                    input spike stream (valid/ready/data)
//   spike_out_*                   output spike stream (valid/ready/data/core)
//   bus_req_o .. bus_wdata_o      registered bus request toward the address decoder
//   bus_gnt_i, bus_rvalid_i/rdata bus accept and read return
//   core_done_i                   per-core calculation-done pulses
module snn_step_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [STEP_W-1:0] num_steps_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [STEP_W-1:0] step_cnt_o,
  input  logic              spike_in_valid_i,
  output logic              spike_in_ready_o,
  input  logic [DATA_W-1:0] spike_in_data_i,
  output logic              spike_out_valid_o,
  input  logic              spike_out_ready_i,
  output logic [DATA_W-1:0] spike_out_data_o,
  output logic              spike_out_core_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [31:0]       bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic [1:0]        core_done_i
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  seq_state_e        state;
  logic              core_sel;
  logic [STEP_W-1:0] num_steps_q;
  logic [1:0]        done_flag;
  logic [TO_W-1:0]   to_cnt;

  logic done_seen;
  logic in_xfer;
  logic out_xfer;
  logic last_step;

  // A done pulse that lands in the first WAIT_DONE cycle counts at once. A
  // pulse that landed on the calc-write grant cycle is held in the flag. Only
  // the selected core is ever looked at.
  assign done_seen = done_flag[core_sel] | core_done_i[core_sel];
  assign in_xfer   = spike_in_valid_i & spike_in_ready_o;
  assign out_xfer  = spike_out_valid_o & spike_out_ready_i;
  assign last_step = core_sel & ((step_cnt_o + STEP_W'(1)) == num_steps_q);

  // All outputs are registered. Each transition loads the output values that
  // the next state needs, so the bus fields stay stable until their grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      core_sel          <= 1'b0;
      num_steps_q       <= '0;
      done_flag         <= '0;
      to_cnt            <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
      step_cnt_o        <= '0;
      spike_in_ready_o  <= 1'b0;
      spike_out_valid_o <= 1'b0;
      spike_out_data_o  <= '0;
      spike_out_core_o  <= 1'b0;
      bus_req_o         <= 1'b0;
      bus_we_o          <= 1'b0;
      bus_addr_o        <= '0;
      bus_wdata_o       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            error_o     <= 1'b0;
            step_cnt_o  <= '0;
            num_steps_q <= num_steps_i;
            core_sel    <= 1'b0;
            if (num_steps_i == '0) begin
              done_o <= 1'b1;
            end else begin
              busy_o           <= 1'b1;
              spike_in_ready_o <= 1'b1;
              state            <= ST_FETCH_IN;
            end
          end
        end
        ST_FETCH_IN: begin
          if (in_xfer) begin
            spike_in_ready_o <= 1'b0;
            bus_req_o        <= 1'b1;
            bus_we_o         <= 1'b1;
            bus_addr_o       <= make_addr(core_sel, REG_SPIKE_IN);
            bus_wdata_o      <= spike_in_data_i;
            state            <= ST_WR_IN;
          end
        end
        ST_WR_IN: begin
          if (bus_gnt_i) begin
            bus_addr_o  <= make_addr(core_sel, REG_EN_CALC);
            bus_wdata_o <= DATA_W'(1);
            state       <= ST_WR_CALC;
          end
        end
        ST_WR_CALC: begin
          if (bus_gnt_i) begin
            bus_req_o           <= 1'b0;
            bus_we_o            <= 1'b0;
            done_flag[core_sel] <= core_done_i[core_sel];
            to_cnt              <= '0;
            state               <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (done_seen) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= make_addr(core_sel, REG_SPIKE_OUT);
            bus_wdata_o <= '0;
            state       <= ST_RD_OUT;
          end else if (to_cnt == TO_LAST) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_RD_OUT: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            state     <= ST_WAIT_RDATA;
          end
        end
        ST_WAIT_RDATA: begin
          if (bus_rvalid_i) begin
            spike_out_valid_o <= 1'b1;
            spike_out_data_o  <= bus_rdata_i;
            spike_out_core_o  <= core_sel;
            state             <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_xfer) begin
            spike_out_valid_o <= 1'b0;
            if (core_sel) begin
              step_cnt_o <= step_cnt_o + STEP_W'(1);
            end
            if (last_step) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              core_sel         <= ~core_sel;
              spike_in_ready_o <= 1'b1;
              state            <= ST_FETCH_IN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_step_sequencer.sv
// tb_snn_step_sequencer
// Self-checking bench for snn_step_sequencer. A responder process plays the
// bus slave, the two cores and both stream endpoints, and it logs what it
// sees. Each test task then compares those logs with expectations that it
// builds from the address map and the per-core cycle cost.
module tb_snn_step_sequencer;

  typedef struct packed { logic [31:0] addr; logic we; logic [31:0] wdata; } txn_t;
  typedef struct packed { logic [31:0] data; logic core; } out_t;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [15:0] num_steps_i;
  logic        busy_o, done_o, error_o;
  logic [15:0] step_cnt_o;
  logic        spike_in_valid_i, spike_in_ready_o;
  logic [31:0] spike_in_data_i;
  logic        spike_out_valid_o, spike_out_ready_i;
  logic [31:0] spike_out_data_o;
  logic        spike_out_core_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  core_done_i;

  int n_checks = 0;
  int n_fail = 0;

  // responder configuration
  int gnt_min, gnt_max, rv_min, rv_max, done_min, done_max, ready_pct;
  bit suppress_done1, glitch_en;

  // responder logs
  txn_t        txn_log[$];
  logic [31:0] in_log[$];
  logic [31:0] rd_log[$];
  out_t        out_log[$];
  int stab_err, req_seen, ready_seen;
  int rd_cnt;

  snn_step_sequencer #(.STEP_W(16), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_steps_i(num_steps_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .step_cnt_o(step_cnt_o),
    .spike_in_valid_i(spike_in_valid_i), .spike_in_ready_o(spike_in_ready_o),
    .spike_in_data_i(spike_in_data_i),
    .spike_out_valid_o(spike_out_valid_o), .spike_out_ready_i(spike_out_ready_i),
    .spike_out_data_o(spike_out_data_o), .spike_out_core_o(spike_out_core_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .core_done_i(core_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The address map is a core select at bit 16 plus a region field at bits 18:17.
  function automatic logic [31:0] exp_addr(input int core, input int region);
    return 32'(core * 65536 + region * 131072);
  endfunction

  // Responder: acts 1 time unit after every rising edge. It looks at what the
  // previous cycle presented and decides this cycle's slave-side inputs.
  initial begin : responder
    bit txn_active;
    int gnt_wait;
    int done_cnt[2];
    int glitch_cnt;
    logic [31:0] cur_addr, cur_wdata, rd_pending;
    logic cur_we;
    logic in_v_prev, in_r_prev, out_v_prev, out_r_prev, out_c_prev;
    logic [31:0] in_d_prev, out_d_prev;
    int c;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; core_done_i = 0;
    spike_in_valid_i = 1; spike_in_data_i = $urandom; spike_out_ready_i = 1;
    txn_active = 0; gnt_wait = 0; done_cnt[0] = 0; done_cnt[1] = 0; glitch_cnt = 0;
    rd_cnt = 0; rd_pending = 0; cur_addr = 0; cur_wdata = 0; cur_we = 0;
    in_v_prev = 0; in_r_prev = 0; out_v_prev = 0; out_r_prev = 0; out_c_prev = 0;
    in_d_prev = 0; out_d_prev = 0;
    forever begin
      @(posedge clk); #1;
      if (rst_i) begin
        bus_gnt_i = 0; bus_rvalid_i = 0; core_done_i = 0;
        txn_active = 0; done_cnt[0] = 0; done_cnt[1] = 0; glitch_cnt = 0; rd_cnt = 0;
        in_v_prev = 0; in_r_prev = 0; out_v_prev = 0; out_r_prev = 0;
        continue;
      end
      // input stream: a new word is offered after each accepted word
      if (in_v_prev && in_r_prev) begin
        in_log.push_back(in_d_prev);
        spike_in_data_i = $urandom;
      end
      if (spike_in_ready_o) ready_seen++;
      // output stream: log transfers and watch for a word that changes while stalled
      if (out_v_prev && out_r_prev)
        out_log.push_back({out_d_prev, out_c_prev});
      else if (out_v_prev && (!spike_out_valid_o || spike_out_data_o !== out_d_prev ||
                              spike_out_core_o !== out_c_prev))
        stab_err++;
      spike_out_ready_i = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      // core done pulses plus an optional stray pulse from core 0
      core_done_i = 0;
      for (int k = 0; k < 2; k++) begin
        if (done_cnt[k] > 0) begin
          done_cnt[k]--;
          if (done_cnt[k] == 0) core_done_i[k] = 1'b1;
        end
      end
      if (glitch_cnt > 0) begin
        glitch_cnt--;
        if (glitch_cnt == 0) core_done_i[0] = 1'b1;
      end
      // read data return
      bus_rvalid_i = 0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus_rvalid_i = 1;
          bus_rdata_i = rd_pending;
        end
      end
      // bus grant
      if (bus_gnt_i) begin
        bus_gnt_i = 0;
        txn_active = 0;
      end
      if (bus_req_o) begin
        req_seen++;
        if (!txn_active) begin
          txn_active = 1;
          cur_addr = bus_addr_o; cur_we = bus_we_o; cur_wdata = bus_wdata_o;
          gnt_wait = $urandom_range(gnt_min, gnt_max);
        end else if (bus_addr_o !== cur_addr || bus_we_o !== cur_we || bus_wdata_o !== cur_wdata) begin
          stab_err++;
        end
        if (gnt_wait == 0) begin
          bus_gnt_i = 1;
          txn_log.push_back({cur_addr, cur_we, cur_wdata});
          c = int'(cur_addr[16]);
          if (cur_we && cur_addr[18:17] == 2'b11) begin
            if (!(c == 1 && suppress_done1)) done_cnt[c] = $urandom_range(done_min, done_max);
            if (c == 1 && glitch_en) glitch_cnt = 2;
          end
          if (!cur_we) begin
            rd_pending = $urandom;
            rd_log.push_back(rd_pending);
            rd_cnt = 1 + $urandom_range(rv_min, rv_max);
          end
        end else begin
          gnt_wait--;
        end
      end
      in_v_prev = spike_in_valid_i; in_r_prev = spike_in_ready_o; in_d_prev = spike_in_data_i;
      out_v_prev = spike_out_valid_o; out_r_prev = spike_out_ready_i;
      out_d_prev = spike_out_data_o; out_c_prev = spike_out_core_o;
    end
  end

  task automatic set_cfg(input int g0, input int g1, input int r0, input int r1,
                         input int d0, input int d1, input int rp, input bit sup, input bit gl);
    @(negedge clk);
    gnt_min = g0; gnt_max = g1; rv_min = r0; rv_max = r1;
    done_min = d0; done_max = d1; ready_pct = rp; suppress_done1 = sup; glitch_en = gl;
    txn_log.delete(); in_log.delete(); rd_log.delete(); out_log.delete();
    stab_err = 0; req_seen = 0; ready_seen = 0;
  endtask

  // Starts a run and counts falling edges until done_o shows. Count 0 is the
  // first falling edge after the start edge. A second start can be pulsed at
  // cycle mid_start while the run is busy.
  task automatic run_seq(input int steps, input int budget, input int mid_start,
                         output int cycles, output bit timed_out,
                         output logic [15:0] step0, output logic err0);
    @(negedge clk);
    num_steps_i = 16'(steps); start_i = 1;
    @(negedge clk);
    start_i = 0; num_steps_i = 16'($urandom);
    step0 = step_cnt_o; err0 = error_o;
    cycles = 0; timed_out = 1;
    while (cycles <= budget) begin
      if (done_o) begin timed_out = 0; break; end
      @(negedge clk);
      cycles++;
      if (cycles == mid_start) begin start_i = 1; num_steps_i = 16'd7; end
      else start_i = 0;
    end
    start_i = 0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({busy_o, done_o, error_o, step_cnt_o} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_status: got %h expected 0", {busy_o, done_o, error_o, step_cnt_o});
    end
    n_checks++;
    if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_bus: got %h expected 0", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o});
    end
    n_checks++;
    if ({spike_in_ready_o, spike_out_valid_o, spike_out_data_o, spike_out_core_o} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_stream: got %h expected 0",
                         {spike_in_ready_o, spike_out_valid_o, spike_out_data_o, spike_out_core_o});
    end
    @(negedge clk);
    rst_i = 0;
  endtask

  task automatic test_single_step;
    int cyc; bit to; logic [15:0] s0; logic e0;
    logic [31:0] addrs[6];
    addrs[0] = 32'h00000; addrs[1] = 32'h60000; addrs[2] = 32'h40000;
    addrs[3] = 32'h10000; addrs[4] = 32'h70000; addrs[5] = 32'h50000;
    set_cfg(0, 0, 0, 0, 3, 3, 100, 0, 0);
    run_seq(1, 200, -1, cyc, to, s0, e0);
    // zero-wait bus: each core costs 6 cycles plus 3 cycles of waiting for done
    n_checks++;
    if (to || cyc != 2 * (6 + 3)) begin
      n_fail++; $display("[TB] FAIL single_done_cycle: got %0d (timeout=%0d) expected %0d", cyc, to, 18);
    end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_at_done: got %b expected 0", busy_o); end
    n_checks++;
    if (txn_log.size() != 6) begin n_fail++; $display("[TB] FAIL single_txn_count: got %0d expected 6", txn_log.size()); end
    for (int k = 0; k < 6 && k < txn_log.size(); k++) begin
      n_checks++;
      if (txn_log[k].addr !== addrs[k]) begin
        n_fail++; $display("[TB] FAIL single_addr[%0d]: got %h expected %h", k, txn_log[k].addr, addrs[k]);
      end
    end
    for (int k = 0; k < 2 && 3 * k + 1 < txn_log.size() && k < in_log.size(); k++) begin
      n_checks++;
      if (txn_log[3 * k].wdata !== in_log[k] || txn_log[3 * k + 1].wdata !== 32'd1) begin
        n_fail++; $display("[TB] FAIL single_wdata[%0d]: got %h/%h expected %h/1", k,
                           txn_log[3 * k].wdata, txn_log[3 * k + 1].wdata, in_log[k]);
      end
    end
    n_checks++;
    if (out_log.size() != 2) begin n_fail++; $display("[TB] FAIL single_out_count: got %0d expected 2", out_log.size()); end
    for (int k = 0; k < out_log.size() && k < rd_log.size(); k++) begin
      n_checks++;
      if (out_log[k] !== {rd_log[k], 1'(k % 2)}) begin
        n_fail++; $display("[TB] FAIL single_out[%0d]: got %h expected %h", k, out_log[k], {rd_log[k], 1'(k % 2)});
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (step_cnt_o !== 16'd1) begin n_fail++; $display("[TB] FAIL single_step_cnt_hold: got %0d expected 1", step_cnt_o); end
  endtask

  task automatic test_random_backpressure;
    int cyc; bit to; logic [15:0] s0; logic e0;
    int core;
    set_cfg(0, 5, 0, 5, 1, 5, 50, 0, 0);
    run_seq(3, 3000, -1, cyc, to, s0, e0);
    n_checks++;
    if (s0 !== 16'd0) begin n_fail++; $display("[TB] FAIL rand_step_cleared: got %0d expected 0", s0); end
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL rand_timeout: got no done within %0d cycles, expected done", cyc); end
    n_checks++;
    if (step_cnt_o !== 16'd3 || error_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rand_final: got steps=%0d err=%b expected steps=3 err=0", step_cnt_o, error_o);
    end
    n_checks++;
    if (txn_log.size() != 18 || out_log.size() != 6) begin
      n_fail++; $display("[TB] FAIL rand_counts: got txn=%0d out=%0d expected 18/6", txn_log.size(), out_log.size());
    end
    for (int k = 0; k < 6; k++) begin
      core = k % 2;
      if (3 * k + 2 < txn_log.size() && k < in_log.size()) begin
        n_checks++;
        if (txn_log[3 * k] !== {exp_addr(core, 0), 1'b1, in_log[k]} ||
            txn_log[3 * k + 1] !== {exp_addr(core, 3), 1'b1, 32'd1} ||
            {txn_log[3 * k + 2].addr, txn_log[3 * k + 2].we} !== {exp_addr(core, 2), 1'b0}) begin
          n_fail++; $display("[TB] FAIL rand_txn[%0d]: got %h %h %h expected core %0d sequence", k,
                             txn_log[3 * k], txn_log[3 * k + 1], txn_log[3 * k + 2], core);
        end
      end
      if (k < out_log.size() && k < rd_log.size()) begin
        n_checks++;
        if (out_log[k] !== {rd_log[k], 1'(core)}) begin
          n_fail++; $display("[TB] FAIL rand_out[%0d]: got %h expected %h", k, out_log[k], {rd_log[k], 1'(core)});
        end
      end
    end
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("[TB] FAIL rand_stability: got %0d changes while stalled expected 0", stab_err); end
  endtask

  task automatic test_timeout;
    int cyc; bit to; logic [15:0] s0; logic e0;
    set_cfg(0, 0, 0, 0, 1, 1, 100, 1, 0);
    run_seq(1, 200, -1, cyc, to, s0, e0);
    // core 0 costs 7 cycles, then core 1 takes 3 cycles to reach WAIT_DONE and waits 16
    n_checks++;
    if (to || cyc < 7 + 3 + 16 || cyc > 7 + 3 + 17) begin
      n_fail++; $display("[TB] FAIL timeout_cycle: got %0d (timeout=%0d) expected 26..27", cyc, to);
    end
    n_checks++;
    if (error_o !== 1'b1 || busy_o !== 1'b0 || step_cnt_o !== 16'd0) begin
      n_fail++; $display("[TB] FAIL timeout_status: got err=%b busy=%b steps=%0d expected 1/0/0", error_o, busy_o, step_cnt_o);
    end
    n_checks++;
    if (out_log.size() != 1) begin n_fail++; $display("[TB] FAIL timeout_out_count: got %0d expected 1", out_log.size()); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (error_o !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_sticky: got %b expected 1", error_o); end
    set_cfg(0, 0, 0, 0, 1, 1, 100, 0, 0);
    run_seq(1, 200, -1, cyc, to, s0, e0);
    n_checks++;
    if (e0 !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_clear_on_start: got %b expected 0", e0); end
    n_checks++;
    if (to || error_o !== 1'b0 || step_cnt_o !== 16'd1) begin
      n_fail++; $display("[TB] FAIL timeout_rerun: got to=%0d err=%b steps=%0d expected 0/0/1", to, error_o, step_cnt_o);
    end
  endtask

  task automatic test_zero_steps;
    int cyc; bit to; logic [15:0] s0; logic e0;
    set_cfg(0, 0, 0, 0, 1, 1, 100, 0, 0);
    run_seq(0, 20, -1, cyc, to, s0, e0);
    n_checks++;
    if (to || cyc != 0) begin n_fail++; $display("[TB] FAIL zero_done_cycle: got %0d (timeout=%0d) expected 0", cyc, to); end
    @(negedge clk);
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_done_width: got %b expected 0", done_o); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (req_seen != 0 || ready_seen != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL zero_activity: got req=%0d ready=%0d busy=%b expected 0/0/0", req_seen, ready_seen, busy_o);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc; bit to; logic [15:0] s0; logic e0;
    int guard;
    set_cfg(0, 0, 4, 4, 1, 1, 100, 0, 0);
    @(negedge clk);
    num_steps_i = 16'd2; start_i = 1;
    @(negedge clk);
    start_i = 0;
    guard = 0;
    while (rd_log.size() == 0 && guard < 200) begin @(negedge clk); guard++; end
    n_checks++;
    if (rd_log.size() == 0) begin n_fail++; $display("[TB] FAIL rst_reach_read: got no read within %0d cycles expected one", guard); end
    @(negedge clk);
    rst_i = 1;
    #1;
    n_checks++;
    if ({busy_o, bus_req_o, spike_in_ready_o, spike_out_valid_o, done_o} !== '0) begin
      n_fail++; $display("[TB] FAIL rst_async_ctrl: got %b expected 00000",
                         {busy_o, bus_req_o, spike_in_ready_o, spike_out_valid_o, done_o});
    end
    n_checks++;
    if ({bus_addr_o, bus_wdata_o, spike_out_data_o, step_cnt_o} !== '0) begin
      n_fail++; $display("[TB] FAIL rst_async_data: got %h expected 0", {bus_addr_o, bus_wdata_o, spike_out_data_o, step_cnt_o});
    end
    @(negedge clk);
    rst_i = 0;
    set_cfg(0, 0, 0, 0, 2, 2, 100, 0, 0);
    run_seq(1, 200, -1, cyc, to, s0, e0);
    n_checks++;
    if (to || cyc != 2 * (6 + 2) || step_cnt_o !== 16'd1) begin
      n_fail++; $display("[TB] FAIL rst_rerun: got cyc=%0d to=%0d steps=%0d expected 16/0/1", cyc, to, step_cnt_o);
    end
    n_checks++;
    if (txn_log.size() == 0 || txn_log[0].addr !== 32'h00000 || out_log.size() != 2 ||
        (out_log.size() == 2 && (out_log[0].core !== 1'b0 || out_log[1].core !== 1'b1))) begin
      n_fail++; $display("[TB] FAIL rst_rerun_order: got txn=%0d out=%0d expected core 0 first, 2 words",
                         txn_log.size(), out_log.size());
    end
  endtask

  task automatic test_ignored_inputs;
    int cyc; bit to; logic [15:0] s0; logic e0;
    set_cfg(0, 0, 0, 0, 4, 4, 100, 0, 1);
    run_seq(2, 400, 5, cyc, to, s0, e0);
    // a stray start or a core 0 pulse during core 1's wait would change the cost
    n_checks++;
    if (to || cyc != 2 * 2 * (6 + 4)) begin
      n_fail++; $display("[TB] FAIL ignore_done_cycle: got %0d (timeout=%0d) expected 40", cyc, to);
    end
    n_checks++;
    if (step_cnt_o !== 16'd2 || out_log.size() != 4 || txn_log.size() != 12) begin
      n_fail++; $display("[TB] FAIL ignore_counts: got steps=%0d out=%0d txn=%0d expected 2/4/12",
                         step_cnt_o, out_log.size(), txn_log.size());
    end
    for (int k = 0; k < out_log.size() && k < rd_log.size(); k++) begin
      n_checks++;
      if (out_log[k] !== {rd_log[k], 1'(k % 2)}) begin
        n_fail++; $display("[TB] FAIL ignore_out[%0d]: got %h expected %h", k, out_log[k], {rd_log[k], 1'(k % 2)});
      end
    end
  endtask

  initial begin
    rst_i = 1; start_i = 0; num_steps_i = 0;
    gnt_min = 0; gnt_max = 0; rv_min = 0; rv_max = 0; done_min = 1; done_max = 1;
    ready_pct = 100; suppress_done1 = 0; glitch_en = 0;
    stab_err = 0; req_seen = 0; ready_seen = 0;
    repeat (2) @(negedge clk);
    test_reset;
    test_single_step;
    test_random_backpressure;
    test_timeout;
    test_zero_steps;
    test_reset_mid_run;
    test_ignored_inputs;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_step_sequencer.md
# snn_step_sequencer

Master-side controller that runs the two-core SNN over a given number of timesteps by issuing bus transactions into the core address map. For each timestep, and for core 0 then core 1, it:
- writes one input spike word;
- triggers calculation;
- waits for the core's done pulse;
- reads back the output spike word and streams it out.

It sits between the host/stream logic and the address decoder, so no host software has to hand-sequence timesteps.

## Interface
Address map used: bit16 = core select; bits18:17 = region (00 spike_in, 01 param_in, 10 spike_out, 11 enable_calc); all other address bits are 0.
- STEP_W, 16, width of timestep count
- DATA_W, 32, bus and spike word width
- TIMEOUT_CYC, 1024, max cycles waiting for core done
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse, sampled only in IDLE
- num_steps_i  in  STEP_W  timesteps to run, sampled with start_i
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle pulse on completion or error
- error_o  out  1  sticky timeout flag, cleared by next accepted start
- step_cnt_o  out  STEP_W  completed timesteps
- spike_in_valid_i / spike_in_ready_o  in/out  1  input spike stream handshake
- spike_in_data_i  in  DATA_W  input spike word
- spike_out_valid_o / spike_out_ready_i  out/in  1  output spike stream handshake
- spike_out_data_o  out  DATA_W  read-back spike word
- spike_out_core_o  out  1  core the word came from
- bus_req_o  out  1  transaction request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  address
- bus_wdata_o  out  DATA_W  write data
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i / bus_rdata_i  in  1/DATA_W  read data return
- core_done_i  in  2  per-core calculation-done pulses

## Operation
- FSM states and transitions:
  - IDLE -> FETCH_IN: on start_i.
  - FETCH_IN -> WR_IN: on input word accepted.
  - WR_IN -> WR_CALC: on gnt.
  - WR_CALC -> WAIT_DONE: on gnt.
  - WAIT_DONE -> RD_OUT: on done seen.
  - RD_OUT -> WAIT_RDATA: on gnt.
  - WAIT_RDATA -> EMIT: on rvalid.
  - EMIT -> NEXT: on output ready.
  - NEXT -> FETCH_IN: next core, or next step.
  - NEXT -> IDLE: last step complete.
- Core select register: starts at 0 and toggles in NEXT. step_cnt increments when core 1 completes. Run ends when step_cnt == num_steps.
- Bus transactions:
  - WR_IN: addr region 00 to the current core; wdata = captured spike word.
  - WR_CALC: region 11; wdata = 1.
  - RD_OUT: region 10, we = 0.
- Done detection:
  - A per-core done flag is cleared when the WR_CALC gnt occurs.
  - The flag is set by core_done_i[core] on or after that cycle.
  - Pulses from the non-selected core are ignored.
- Timeout:
  - The counter runs only in WAIT_DONE.
  - Reaching TIMEOUT_CYC sets error_o, pulses done_o and returns to IDLE.
- start_i while busy is ignored.
- num_steps_i == 0: done_o pulses the cycle after start, with no bus or stream activity.
- step_cnt_o holds its final value until the next accepted start, which clears it.

## Timing
- Reset value of every output is 0, including bus_addr_o and data outputs.
- Reset mid-operation forces IDLE immediately. bus_req_o and the valid/ready outputs drop asynchronously, and the partial step is discarded.
- Start accepted at cycle 0; spike_in_ready_o is high from cycle 1.
- Bus request rules:
  - bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o are registered and stable from assertion until the gnt cycle.
  - req deasserts the cycle after gnt unless the next state also requests.
- Read data: rvalid may arrive any cycle after the RD_OUT gnt. rvalid outside WAIT_RDATA is ignored.
- Output stream: spike_out_valid_o holds with stable data/core until ready. Transfer occurs on valid & ready.
- Minimum cost is 7 cycles per core (zero-wait bus, done on the first WAIT_DONE cycle, ready held high), i.e. 14 cycles per timestep.
- done_o pulses in the cycle after the final EMIT transfer; busy_o falls in the same cycle.

## Structure
- Package snn_ctrl_pkg holds:
  - region constants REG_SPIKE_IN=2'b00, REG_PARAM_IN=2'b01, REG_SPIKE_OUT=2'b10, REG_EN_CALC=2'b11;
  - bit positions CORE_BIT=16, REGION_LSB=17;
  - the FSM state enum;
  - a function building the 32-bit address from core and region.
- Single module; no sub-module needed. The timeout counter stays inline.

## Test plan
- num_steps=1, zero-wait bus, done 3 cycles after calc, ready high -> transaction addresses 0x00000, 0x60000, 0x40000, 0x10000, 0x70000, 0x50000 in order; two output words tagged core 0 then core 1; done_o at the expected cycle; step_cnt_o=1.
- num_steps=3, random gnt/rvalid delays (0-5) and random spike_out_ready backpressure -> 6 output words match the rdata model in order; bus address stable while waiting for gnt.
- core 1 never asserts done, TIMEOUT_CYC=16 -> error_o=1, done_o pulses, IDLE, step_cnt_o=0; the next start clears error_o.
- num_steps=0 -> done_o one cycle after start, no bus_req_o, spike_in_ready_o never high.
- Async reset asserted during WAIT_RDATA -> all outputs 0 immediately; a new start afterwards runs cleanly from core 0.
- start_i pulsed while busy, plus core_done_i[0] pulsed while waiting on core 1 -> both ignored; sequence unchanged.
